// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA3-512 job controller.
package sha3_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KRST,
        S_FEED,
        S_PAD,
        S_DRAIN,
        S_WAIT_HASH,
        S_DONE
    } feed_state_e;

    localparam int BEAT_BYTES = 16;
    localparam int WORD_BYTES = 8;
    localparam int DIGEST_W   = 512;

endpackage

// File: rtl/sha3_burst_issuer.sv
// Splits a job into 128-bit read bursts and runs the rd_req/rd_ack handshake.
module sha3_burst_issuer
    import sha3_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 32,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [LEN_W-1:0]  beats_i,
    input  logic              fifo_half_full_i,
    input  logic              rd_ack_i,
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [8:0]        rd_beats_o,
    output logic              issue_done_o
);

    localparam logic [LEN_W-1:0] MAXB  = LEN_W'(MAX_BURST);
    localparam int               BSH   = $clog2(BEAT_BYTES);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              req_q, req_d;
    logic [8:0]        beats_q, beats_d;
    logic [8:0]        burst_len;

    assign burst_len = (rem_q > MAXB) ? 9'(MAX_BURST) : rem_q[8:0];

    always_comb begin
        addr_d  = addr_q;
        rem_d   = rem_q;
        req_d   = req_q;
        beats_d = beats_q;
        if (load_i) begin
            addr_d  = base_i;
            rem_d   = beats_i;
            req_d   = 1'b0;
            beats_d = '0;
        end else if (req_q && rd_ack_i) begin
            req_d   = 1'b0;
            addr_d  = addr_q + (ADDR_W'(beats_q) << BSH);
            rem_d   = rem_q - LEN_W'(beats_q);
            beats_d = '0;
        end else if (!req_q && rem_q != '0 && !fifo_half_full_i) begin
            // half-full only gates raising; a pending request stays put
            req_d   = 1'b1;
            beats_d = burst_len;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            rem_q   <= '0;
            req_q   <= 1'b0;
            beats_q <= '0;
        end else begin
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            req_q   <= req_d;
            beats_q <= beats_d;
        end
    end

    assign rd_req_o     = req_q;
    assign rd_addr_o    = addr_q;
    assign rd_beats_o   = beats_q;
    assign issue_done_o = (rem_q == '0) && !req_q;

endmodule

// File: rtl/sha3_job_ctrl.sv
// SHA3-512 job sequencer: burst reads, Keccak feed with last/pad control,
// digest capture and done/err reporting.
module sha3_job_ctrl
    import sha3_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   msg_addr,
    input  logic [LEN_W-1:0]    msg_len,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                rd_req,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic [8:0]          rd_beats,
    input  logic                rd_ack,
    input  logic                fifo_half_full,
    input  logic                word_valid,
    input  logic [63:0]         word_data,
    output logic                word_pop,
    output logic                keccak_rst,
    output logic [63:0]         keccak_input,
    output logic                in_ready,
    output logic                is_last,
    output logic [2:0]          byte_num,
    input  logic                buffer_full,
    input  logic                out_ready,
    input  logic [DIGEST_W-1:0] keccak_out,
    output logic [DIGEST_W-1:0] hash
);

    feed_state_e         state_q, state_d;
    logic [LEN_W-1:0]    words_q, words_d;
    logic [2:0]          rem_q, rem_d;
    logic                drop_q, drop_d;
    logic                err_q, err_d;
    logic                done_q, busy_q, krst_q;
    logic [DIGEST_W-1:0] hash_q, hash_d;

    logic [LEN_W:0]   len_ext;
    logic [LEN_W-1:0] w_cnt, b_cnt;
    logic             aligned, accept, last_word, issue_done;
    logic [63:0]      keep_mask;

    assign len_ext   = {1'b0, msg_len};
    assign w_cnt     = LEN_W'((len_ext + (LEN_W+1)'(7)) >> 3);
    assign b_cnt     = LEN_W'((len_ext + (LEN_W+1)'(15)) >> 4);
    assign aligned   = (msg_addr[3:0] == 4'd0);
    assign accept    = (state_q == S_IDLE) && start && aligned;
    assign last_word = (words_q == LEN_W'(1));
    assign keep_mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> {rem_q, 3'b000});

    sha3_burst_issuer #(
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .MAX_BURST (MAX_BURST)
    ) u_issuer (
        .clk              (clk),
        .reset            (reset),
        .load_i           (accept),
        .base_i           (msg_addr),
        .beats_i          (b_cnt),
        .fifo_half_full_i (fifo_half_full),
        .rd_ack_i         (rd_ack),
        .rd_req_o         (rd_req),
        .rd_addr_o        (rd_addr),
        .rd_beats_o       (rd_beats),
        .issue_done_o     (issue_done)
    );

    always_comb begin
        state_d      = state_q;
        words_d      = words_q;
        rem_d        = rem_q;
        drop_d       = drop_q;
        err_d        = err_q;
        hash_d       = hash_q;
        word_pop     = 1'b0;
        in_ready     = 1'b0;
        is_last      = 1'b0;
        byte_num     = 3'd0;
        keccak_input = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start && aligned) begin
                    state_d = S_KRST;
                    err_d   = 1'b0;
                    words_d = w_cnt;
                    rem_d   = msg_len[2:0];
                    drop_d  = w_cnt[0];
                end else if (start) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_KRST: state_d = (words_q == '0) ? S_PAD : S_FEED;
            S_FEED: begin
                if (word_valid && !buffer_full) begin
                    word_pop     = 1'b1;
                    in_ready     = 1'b1;
                    keccak_input = word_data;
                    words_d      = words_q - LEN_W'(1);
                    if (last_word) begin
                        if (rem_q != 3'd0) begin
                            is_last      = 1'b1;
                            byte_num     = rem_q;
                            keccak_input = word_data & keep_mask;
                        end
                        // odd word count leaves a spare word in the last beat
                        if (drop_q)              state_d = S_DRAIN;
                        else if (rem_q == 3'd0)  state_d = S_PAD;
                        else                     state_d = S_WAIT_HASH;
                    end
                end
            end
            S_DRAIN: begin
                if (word_valid) begin
                    word_pop = 1'b1;
                    state_d  = (rem_q == 3'd0) ? S_PAD : S_WAIT_HASH;
                end
            end
            S_PAD: begin
                if (!buffer_full) begin
                    in_ready = 1'b1;
                    is_last  = 1'b1;
                    state_d  = S_WAIT_HASH;
                end
            end
            S_WAIT_HASH: begin
                if (out_ready && issue_done) begin
                    hash_d  = keccak_out;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            words_q <= '0;
            rem_q   <= 3'd0;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            krst_q  <= 1'b1;
            hash_q  <= '0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            rem_q   <= rem_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
            done_q  <= (state_d == S_DONE);
            busy_q  <= state_d inside {S_KRST, S_FEED, S_PAD, S_DRAIN, S_WAIT_HASH};
            krst_q  <= (state_d == S_KRST);
            hash_q  <= hash_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign keccak_rst = krst_q;
    assign hash       = hash_q;

    logic unused_ok;
    assign unused_ok = accept;

endmodule

// File: doc/sha3_job_ctrl.md
Name: sha3_job_ctrl

Overview:
Sequences one SHA3-512 hash job end to end. Accepts a start command (message address and length) and issues 128-bit burst read requests to the OCM/bus master, with backpressure from the bus FIFO half-full flag. Pops 64-bit words from the FIFO and drives the Keccak core input handshake, including last-word and padding control. Captures the 512-bit digest and reports done.

Parameters:
ADDR_W, 32, byte address width
LEN_W, 32, message length width (bytes)
MAX_BURST, 16, max 128-bit beats per read request (power of 2, 1..256)

Ports:
clk  in  1  clock
reset  in  1  reset
start  in  1  job start pulse; ignored while busy
msg_addr  in  ADDR_W  message base byte address; bits[3:0] must be 0
msg_len  in  LEN_W  message length in bytes (0 legal)
busy  out  1  job in progress
done  out  1  one-cycle pulse when hash valid or job rejected
err  out  1  sticky until next start: misaligned msg_addr
rd_req  out  1  burst request valid, held until rd_ack
rd_addr  out  ADDR_W  burst byte address
rd_beats  out  9  beats in burst (1..MAX_BURST)
rd_ack  in  1  request accepted this cycle
fifo_half_full  in  1  no new request may be raised while high
word_valid  in  1  FIFO non-empty
word_data  in  64  FIFO head word
word_pop  out  1  pop FIFO head this cycle
keccak_rst  out  1  Keccak core reset
keccak_input  out  64  Keccak data
in_ready  out  1  Keccak data valid
is_last  out  1  final Keccak word
byte_num  out  3  valid bytes in final word (0..7)
buffer_full  in  1  Keccak cannot accept
out_ready  in  1  Keccak digest valid
keccak_out  in  512  Keccak digest
hash  out  512  captured digest

Behaviour:
- Reset is synchronous, active-high, on clk. On reset: all outputs 0, except keccak_rst=1 and hash=0. Both FSMs return to IDLE, and all counters clear. Reset mid-job abandons the job and drops outstanding bursts. The FIFO is reset externally by the same reset.
- Derived counts: W = ceil(msg_len/8) words, B = ceil(msg_len/16) beats, R = msg_len mod 8. Drop = 1 when W is odd, meaning the trailing word of the last beat is popped and discarded.
- Start in IDLE:
  - If msg_addr[3:0]!=0: set err, pulse done the next cycle, stay not busy.
  - Otherwise: busy=1, keccak_rst=1 for exactly 1 cycle (KRST), then FEED.
- Request issuer, concurrent with the feeder:
  - While beats remaining >0, fifo_half_full=0 and rd_req=0, raise rd_req with rd_addr = next address and rd_beats = min(MAX_BURST, remaining).
  - On rd_req&&rd_ack: advance address by 16*rd_beats, decrement remaining.
  - rd_req and its fields stay stable until ack, even if fifo_half_full rises.
- Feeder FSM states: IDLE, KRST, FEED, PAD, DRAIN, WAIT_HASH, DONE.
  - FEED: when word_valid && !buffer_full, assert word_pop and in_ready the same cycle. keccak_input = word_data.
  - FEED, on the W-th word with R!=0: is_last=1, byte_num=R. Bytes below the top R bytes are forced to 0. Valid bytes occupy the MSBs [63:64-8R].
  - After the W-th word: go to DRAIN if Drop, otherwise go to PAD if R==0, otherwise WAIT_HASH.
  - DRAIN: pop one word when word_valid, with in_ready=0. Then go to PAD if R==0, else WAIT_HASH.
  - PAD: when !buffer_full, in_ready=1, is_last=1, byte_num=0, keccak_input=0 for one cycle, then WAIT_HASH.
  - msg_len==0: KRST goes directly to PAD. No bursts are issued.
  - WAIT_HASH: on out_ready, hash<=keccak_out, then DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- in_ready is never asserted while buffer_full=1. word_pop is never asserted without word_valid. word_pop and in_ready are combinational from state and inputs; all other outputs are registered.
- start while busy is ignored. hash holds its value until the next job's capture.

Decomposition:
- Package sha3_pkg: feeder state enum, BEAT_BYTES=16, WORD_BYTES=8, DIGEST_W=512.
- One sub-module, sha3_burst_issuer: address/remaining counter and rd_req handshake. Inputs: job load, base, B, fifo_half_full. Output: issue_done.

Test Plan:
- msg_len=0, addr 0x0 -> keccak_rst 1 cycle, no rd_req, one in_ready with is_last=1, byte_num=0; out_ready -> hash captured, done pulse.
- msg_len=20, addr 0x100 -> one rd_req (addr 0x100, beats 2); 3 words fed, 3rd with is_last=1, byte_num=4, low 4 bytes zeroed; 4th word popped without in_ready.
- msg_len=16*40=640 -> rd_req bursts of 16, 16, 8 at 0x0, 0x100, 0x200; hold fifo_half_full=1 between them -> no new request until it drops; 80 words fed, then PAD with byte_num=0.
- buffer_full toggled every other cycle during FEED -> no in_ready/word_pop while high; word order and count preserved.
- msg_addr=0x104 -> err=1, done pulse, no rd_req, busy stays 0.
- reset asserted mid-FEED on a 640-byte job -> all outputs return to reset values next cycle; a following 20-byte job completes correctly.
